// File: rtl/circuit1_result_collector_pkg.sv
// Purpose : shared widths and the {z,x} result record for the Circuit1 collector.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package c1_pkg;

  localparam int C1_ZW = 8;
  localparam int C1_XW = 16;

  typedef struct packed {
    logic [C1_ZW-1:0] z;
    logic [C1_XW-1:0] x;
  } c1_result_t;

endpackage

// File: rtl/circuit1_result_collector_if.sv
// Purpose : operand-side and result-side handshake bundle of the collector.
// Latency : n/a (wiring only).
// Backpressure: in_ready toward the operand source, out_valid/out_ready toward the consumer.
// slave  = collector side, master = operand source + result consumer side.
interface circuit1_result_collector_if #(
  parameter int ZW = 8,
  parameter int XW = 16,
  parameter int CW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [ZW-1:0] z_in;
  logic [XW-1:0] x_in;
  logic          out_valid;
  logic          out_ready;
  logic [ZW-1:0] out_z;
  logic [XW-1:0] out_x;
  logic          overflow;
  logic [CW-1:0] result_cnt;

  modport slave (
    input  in_valid, z_in, x_in, out_ready,
    output in_ready, out_valid, out_z, out_x, overflow, result_cnt
  );

  modport master (
    output in_valid, z_in, x_in, out_ready,
    input  in_ready, out_valid, out_z, out_x, overflow, result_cnt
  );
endinterface

// File: rtl/c1_sync_fifo.sv
// Purpose : synchronous first-word-fall-through FIFO, DEPTH entries of W bits.
// Latency : a push is visible on rdata/occ the next cycle (no same-cycle bypass).
// Backpressure: none internally; pushes are ignored when full without a pop, pops when empty.
// Ports: clk, rst_n (async, active-low), push, pop, wdata, rdata (head), occ (0..DEPTH).
module c1_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] occ
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, last_ptr;
  logic [AW:0]   occ_q, occ_d;
  logic          do_push, do_pop, full;

  assign full    = (occ_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && (occ_q != '0);
  assign do_push = push && (!full || do_pop);

  always_comb begin
    occ_d = occ_q;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // When empty, show the slot just behind rd_ptr so the last-read entry holds on the output.
  assign last_ptr = rd_ptr_q - 1'b1;
  assign rdata    = (occ_q == '0) ? mem_q[last_ptr] : mem_q[rd_ptr_q];
  assign occ      = occ_q;

endmodule

// File: rtl/circuit1_result_collector.sv
// Purpose : re-aligns Circuit1 z (cycle T) with x (cycle T+1), buffers {z,x} in a FIFO.
// Latency : out_valid rises 2 cycles after an accepted in_valid into an empty FIFO.
// Backpressure: in_ready drops when occupancy plus the in-flight stage-1 result would fill the FIFO.
// Ports: Clk, Rst (async, active-low), bus (slave side of circuit1_result_collector_if).
module circuit1_result_collector
  import c1_pkg::*;
#(
  parameter int ZW    = C1_ZW,
  parameter int XW    = C1_XW,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic Clk,
  input  logic Rst,
  circuit1_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [ZW-1:0] z;
    logic [XW-1:0] x;
  } res_t;

  logic          v1_q, v1_d;
  logic [ZW-1:0] z1_q, z1_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc, pop;
  logic [AW:0]   occ;
  logic [AW+1:0] fill;
  res_t          wdata, rdata;

  // Counting the stage-1 result guarantees its push next cycle always finds room.
  assign fill         = {1'b0, occ} + {{(AW+1){1'b0}}, v1_q};
  assign bus.in_ready = (fill < (AW+2)'(DEPTH));
  assign acc          = bus.in_valid && bus.in_ready;

  assign wdata.z = z1_q;
  assign wdata.x = bus.x_in;
  assign pop     = bus.out_valid && bus.out_ready;

  always_comb begin
    v1_d  = acc;
    z1_d  = acc ? bus.z_in : z1_q;
    ovf_d = ovf_q | (bus.in_valid & ~bus.in_ready);
    cnt_d = cnt_q;
    if (v1_q && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      v1_q  <= 1'b0;
      z1_q  <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      z1_q  <= z1_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  c1_sync_fifo #(.DEPTH(DEPTH), .W(ZW + XW)) u_fifo (
    .clk   (Clk),
    .rst_n (Rst),
    .push  (v1_q),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .occ   (occ)
  );

  assign bus.out_valid  = (occ != '0);
  assign bus.out_z      = rdata.z;
  assign bus.out_x      = rdata.x;
  assign bus.overflow   = ovf_q;
  assign bus.result_cnt = cnt_q;

endmodule
